apa102_stream_decoder: RTL
==========================

# apa102_stream_decoder

Receive-side decoder for the two-wire clock/data LED-strip stream driven by the matrix display driver. It oversamples `sclk`/`sdi` on a faster local clock and frames the stream into start frame, 32-bit LED frames and end/gap frames. Each LED word is emitted as a one-cycle pixel record with brightness and colour. The block sits directly downstream of the driver, as a loopback monitor in FPGA builds and as the scoreboard front-end in the bench.

## Interface
Parameters:
- `MAX_PIXELS`, default 64: largest legal number of LED frames per refresh.
- `IDX_W`, default 7: width of the pixel index and count outputs. Must satisfy 2^IDX_W > MAX_PIXELS.

Ports:
- `clk`, in, 1: local sampling clock.
- `reset`, in, 1: synchronous, active-high.
- `sclk`, in, 1: stream clock, asynchronous to `clk`.
- `sdi`, in, 1: stream data, asynchronous to `clk`.
- `pix_valid`, out, 1: one-cycle pulse; pixel record fields are valid in that cycle.
- `pix_index`, out, IDX_W: 0-based position of the LED frame within the current refresh.
- `pix_bright`, out, 5: 5-bit global brightness field.
- `pix_b`, out, 8: blue byte.
- `pix_g`, out, 8: green byte.
- `pix_r`, out, 8: red byte.
- `frame_done`, out, 1: one-cycle pulse on each completed refresh.
- `frame_pixels`, out, IDX_W: LED-frame count of the refresh just completed; held until the next `frame_done`.
- `err`, out, 1: one-cycle pulse on any framing violation.
- `synced`, out, 1: level; high while the decoder is locked to the framing.

## Operation
- **Input conditioning**
  - `sclk` and `sdi` each pass through a 2-flop synchroniser.
  - A registered copy of the synchronised `sclk` is used for edge detection.
- **Bit sampling**
  - One bit is taken per detected `sclk` falling edge, using the synchronised `sdi`.
  - The driver changes data on the rising edge, so data is stable at the falling edge.
- **Bit order**: MSB first within each 32-bit word.
- **LED word layout**, bits 31..0:
  - [31:29] header, must be 111.
  - [28:24] brightness.
  - [23:16] blue.
  - [15:8] green.
  - [7:0] red.
- **States**
  - **HUNT**: count consecutive 0 bits; a 1 clears the count. At 32 zeros, go to SYNCED.
  - **SYNCED**: extra 0s are ignored. A 1 loads it as bit 31, sets the bit count to 1, and goes to LED.
  - **LED**: shift in bits until 32 have been collected.
    - Header ≠ 111: pulse `err`, go to HUNT.
    - Else pulse `pix_valid` with `pix_index` = pixel counter, increment the counter, go to GAP.
  - **GAP**:
    - A 1 starts the next LED word (go to LED).
    - A 0 counts zeros. At 32 zeros, pulse `frame_done`, load `frame_pixels` ← pixel counter, clear the counter, go to SYNCED. The trailing zeros also act as the next start frame.
    - Zeros beyond 32 are absorbed in SYNCED.
- **Overflow**
  - If an LED word completes while the pixel counter = MAX_PIXELS: no `pix_valid`; pulse `err`; go to HUNT.
  - The counter never wraps.
- **Zero-pixel refresh**: a refresh with zero LED frames (SYNCED → 32 zeros) produces no `frame_done`.
- **Partial words**: a GAP zero-run of 1–31 zeros followed by a 1 is legal and starts a new LED word. The zero count is cleared.
- **Error side effects**: any `err` clears the pixel counter and the zero count. `frame_pixels` keeps its last value.
- **`synced`**: high in SYNCED, LED and GAP; low in HUNT.

## Timing
- **Reset values**: all outputs 0; state HUNT; counters 0.
- **Reset mid-word**: the partial word is discarded; no pulses are emitted in the cycle after reset.
- **Input rate**: `sclk` high and low phases must each be ≥ 3 `clk` cycles. Faster input is out of scope and its behaviour is undefined.
- **Latency**: `pix_valid`, `frame_done` and `err` assert exactly 4 `clk` cycles after the `sclk` falling edge that carries the deciding bit:
  - 2 synchroniser flops;
  - 1 edge-detect register;
  - 1 output register.
- **Pulse width**: all pulses are exactly 1 cycle. `pix_valid` and `frame_done` never assert in the same cycle.
- **Pixel fields**: registered; they change only in `pix_valid` cycles.
- **Simultaneous events**: if `reset` and a completing edge coincide, reset wins.

## Test plan
- **Nominal refresh**: 32 zeros, then 64 words of 0xF0000F00, then 64 zeros.
  - Expect 64 `pix_valid` pulses, indices 0..63, bright=16, b=0x00, g=0x0F, r=0x00.
  - Expect one `frame_done` with `frame_pixels`=64.
- **Back-to-back refreshes**: two nominal refreshes with exactly 32 zeros between them.
  - The second refresh decodes with indices restarting at 0.
  - `synced` never drops.
- **Bad header**: start frame, then 0xD0070000.
  - Expect `err` 4 cycles after the 32nd bit, `synced`=0, and no `pix_valid`.
  - A following 32 zeros plus a good word recovers: index 0 is emitted.
- **Overflow**: with MAX_PIXELS=4, send 5 good words.
  - Expect indices 0..3, then `err` and no fifth `pix_valid`.
- **Reset mid-word**: assert `reset` after 20 bits of a word.
  - All outputs read 0 in the cycle after reset.
  - A fresh 32 zeros plus a word decodes at index 0.
- **Edge case**: a 31-zero gap followed by a 1 is treated as an LED-word start, not `frame_done`.
  - `sclk` phases held at exactly 3 `clk` cycles decode correctly.

Source files
------------

// File: rtl/apa102_stream_decoder.sv
// apa102_stream_decoder: oversampling decoder that turns an APA102 sclk/sdi stream into pixel records and refresh markers.
module apa102_stream_decoder #(
  parameter int MAX_PIXELS = 64,
  parameter int IDX_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sdi,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_index,
  output logic [4:0]       pix_bright,
  output logic [7:0]       pix_b,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_r,
  output logic             frame_done,
  output logic [IDX_W-1:0] frame_pixels,
  output logic             err,
  output logic             synced
);
  typedef enum logic [1:0] {S_HUNT, S_SYNC, S_LED, S_GAP} state_t;
  localparam logic [IDX_W-1:0] MAX_P = IDX_W'(MAX_PIXELS);
  logic sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_d1_q, sclk_d1_d;
  logic sdi_s1_q, sdi_s1_d, sdi_s2_q, sdi_s2_d;
  logic fall_q, fall_d, bit_q, bit_d;
  state_t state_q, state_d;
  logic [4:0] zcnt_q, zcnt_d, bcnt_q, bcnt_d;
  logic [30:0] shift_q, shift_d;
  logic [IDX_W-1:0] pcnt_q, pcnt_d;
  logic pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0] pix_index_q, pix_index_d;
  logic [28:0] pix_data_q, pix_data_d;
  logic frame_done_q, frame_done_d;
  logic [IDX_W-1:0] frame_pixels_q, frame_pixels_d;
  logic err_q, err_d;
  logic [31:0] word;
  assign word = {shift_q, bit_q};
  always_comb begin
    sclk_s1_d = sclk;
    sclk_s2_d = sclk_s1_q;
    sclk_d1_d = sclk_s2_q;
    sdi_s1_d = sdi;
    sdi_s2_d = sdi_s1_q;
    fall_d = sclk_d1_q & ~sclk_s2_q;
    bit_d = sdi_s2_q;
    state_d = state_q;
    zcnt_d = zcnt_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    pcnt_d = pcnt_q;
    pix_valid_d = 1'b0;
    pix_index_d = pix_index_q;
    pix_data_d = pix_data_q;
    frame_done_d = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_d = 1'b0;
    if (fall_q) begin
      case (state_q)
        S_HUNT: begin
          zcnt_d = bit_q ? 5'd0 : zcnt_q + 5'd1;
          state_d = (!bit_q && zcnt_q == 5'd31) ? S_SYNC : S_HUNT;
        end
        S_SYNC: begin
          shift_d = bit_q ? 31'd1 : shift_q;
          bcnt_d = bit_q ? 5'd1 : bcnt_q;
          state_d = bit_q ? S_LED : S_SYNC;
        end
        S_LED: begin
          shift_d = word[30:0];
          bcnt_d = bcnt_q + 5'd1;
          if (bcnt_q == 5'd31) begin
            zcnt_d = 5'd0;
            // a bad header and a pixel-count overflow are both framing errors
            if (word[31:29] != 3'b111 || pcnt_q == MAX_P) begin
              err_d = 1'b1;
              pcnt_d = '0;
              state_d = S_HUNT;
            end else begin
              pix_valid_d = 1'b1;
              pix_index_d = pcnt_q;
              pix_data_d = word[28:0];
              pcnt_d = pcnt_q + IDX_W'(1);
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (bit_q) begin
            shift_d = 31'd1;
            bcnt_d = 5'd1;
            zcnt_d = 5'd0;
            state_d = S_LED;
          end else if (zcnt_q == 5'd31) begin
            frame_done_d = 1'b1;
            frame_pixels_d = pcnt_q;
            pcnt_d = '0;
            zcnt_d = 5'd0;
            state_d = S_SYNC;
          end else begin
            zcnt_d = zcnt_q + 5'd1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_d1_q <= 1'b0;
      sdi_s1_q <= 1'b0;
      sdi_s2_q <= 1'b0;
      fall_q <= 1'b0;
      bit_q <= 1'b0;
      state_q <= S_HUNT;
      zcnt_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      pcnt_q <= '0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
      pix_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_pixels_q <= '0;
      err_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk_s1_d;
      sclk_s2_q <= sclk_s2_d;
      sclk_d1_q <= sclk_d1_d;
      sdi_s1_q <= sdi_s1_d;
      sdi_s2_q <= sdi_s2_d;
      fall_q <= fall_d;
      bit_q <= bit_d;
      state_q <= state_d;
      zcnt_q <= zcnt_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      pcnt_q <= pcnt_d;
      pix_valid_q <= pix_valid_d;
      pix_index_q <= pix_index_d;
      pix_data_q <= pix_data_d;
      frame_done_q <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      err_q <= err_d;
    end
  end
  assign pix_valid = pix_valid_q;
  assign pix_index = pix_index_q;
  assign {pix_bright, pix_b, pix_g, pix_r} = pix_data_q;
  assign frame_done = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign err = err_q;
  assign synced = state_q != S_HUNT;
endmodule
